// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
// Covers the queue entry layout, the NOP encoding and the index-width helper.
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } ifq_entry_t;

  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Circular buffer of fetched instructions with their PC+4. Flush clears it in one cycle.
// DEPTH must be a power of two so the pointers wrap by overflow.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  ifq_entry_t                    push_entry,
  input  logic                          pop,
  input  logic                          flush,
  output ifq_entry_t                    head,
  output logic                          empty,
  output logic [idx_width(DEPTH):0]     count
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CW    = IDX_W + 1;

  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  ifq_entry_t       mem_q [DEPTH];
  ifq_entry_t       mem_d [DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

  // The issue-side space check must make an unpopped push into a full queue impossible.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: owns the fetch PC, issues imem reads and queues returned instructions.
// Optional macro IFETCH_BYPASS_EN presents a returning response on if_* when the queue is empty.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [31:0]                   imem_data,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  input  logic                          stall,
  output logic                          if_valid,
  output logic [31:0]                   if_instr,
  output logic [31:0]                   if_pcplus4,
  output logic [idx_width(DEPTH):0]     q_count
);

  localparam int CW = idx_width(DEPTH) + 1;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic        inflight_q, inflight_d;
  logic        drop_q, drop_d;

  logic          fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0] fifo_count;
  ifq_entry_t    fifo_head, resp_entry, head_entry;
  logic          resp_valid, pop_req;
  logic [CW:0]   occupancy;

  assign occupancy  = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
  assign imem_req   = !rst && !redirect && (occupancy < (CW + 1)'(DEPTH));
  assign imem_addr  = fetch_pc_q[ADDR_W+1:2];

  assign resp_valid         = inflight_q && !drop_q;
  assign resp_entry.instr   = imem_data;
  assign resp_entry.pcplus4 = issued_pc_q + 32'd4;

`ifdef IFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = fifo_empty && resp_valid;
  assign if_valid   = !fifo_empty || bypass_hit;
  assign head_entry = fifo_empty ? resp_entry : fifo_head;
  assign pop_req    = if_valid && !stall && !redirect;
  // A bypassed response consumed on arrival never enters the queue.
  assign fifo_push  = resp_valid && !redirect && !(bypass_hit && pop_req);
  assign fifo_pop   = pop_req && !fifo_empty;
`else
  assign if_valid   = !fifo_empty;
  assign head_entry = fifo_head;
  assign pop_req    = if_valid && !stall && !redirect;
  assign fifo_push  = resp_valid && !redirect;
  assign fifo_pop   = pop_req;
`endif

  assign if_instr   = if_valid ? head_entry.instr   : NOP_INSTR;
  assign if_pcplus4 = if_valid ? head_entry.pcplus4 : 32'h0;
  assign q_count    = fifo_count;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = imem_req;
    drop_d      = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      drop_d     = inflight_q;
    end else if (imem_req) begin
      fetch_pc_d  = fetch_pc_q + 32'd4;
      issued_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= PC_RESET;
      issued_pc_q <= PC_RESET;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (resp_entry),
    .pop        (fifo_pop),
    .flush      (redirect),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: scoreboard of expected head entries plus per-scenario checks.
module tb_ifetch_queue;
  import ifetch_pkg::*;

`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pcplus4;
  logic [2:0]  q_count;

  int tests = 0;
  int fails = 0;
  ifq_entry_t sb[$];

  ifetch_queue #(.DEPTH(4), .PC_RESET(32'h0), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .if_valid(if_valid), .if_instr(if_instr),
    .if_pcplus4(if_pcplus4), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x1000_0000 + k, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_data <= 32'h1000_0000 + {22'b0, imem_addr};
  end

  function automatic void load_stream(input logic [31:0] start_pc, input int n);
    logic [31:0] pc;
    ifq_entry_t  e;
    pc = start_pc;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      e.instr   = 32'h1000_0000 + {22'b0, pc[11:2]};
      e.pcplus4 = pc + 32'd4;
      sb.push_back(e);
      pc = pc + 32'd4;
    end
  endfunction

  // Every delivered head entry must match the next expected one, in order.
  always @(negedge clk) begin : monitor
    ifq_entry_t e;
    if (!rst && if_valid && !stall && !redirect) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got instr %h expected no delivery", if_instr);
      end else begin
        e = sb.pop_front();
        if (if_instr !== e.instr || if_pcplus4 !== e.pcplus4) begin
          fails++;
          $display("FAIL sb_order: got %h/%h expected %h/%h", if_instr, if_pcplus4, e.instr, e.pcplus4);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    load_stream(32'h0, 64);
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    cyc();
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      fails++; $display("FAIL reset_hold: got req=%b valid=%b expected 0/0", imem_req, if_valid);
    end
    cyc();
    rst = 1'b0;
    load_stream(32'h0, 64);
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pcplus4 !== 32'h0 || q_count !== 3'd0) begin
      fails++;
      $display("FAIL reset_out: got %b %h %h %0d expected 0 0 0 0", if_valid, if_instr, if_pcplus4, q_count);
    end
    tests++;
    if (imem_addr !== 10'h0) begin
      fails++; $display("FAIL reset_addr: got %h expected 000", imem_addr);
    end
  endtask

  task automatic test_free_run();
    for (int c = 1; c <= LAT + 9; c++) begin
      cyc();
      @(negedge clk);
      tests++;
      if (if_valid !== (c >= LAT)) begin
        fails++; $display("FAIL free_valid c%0d: got %b expected %b", c, if_valid, (c >= LAT));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 1; c <= LAT + 12; c++) begin
      cyc();
      if (c == LAT) stall = 1'b1;
      if (c == LAT + 6) stall = 1'b0;
      @(negedge clk);
      if (c >= LAT && c < LAT + 6) begin
        tests++;
        if (if_valid !== 1'b1 || if_instr !== 32'h1000_0000) begin
          fails++; $display("FAIL stall_head c%0d: got %b %h expected 1 10000000", c, if_valid, if_instr);
        end
      end
      if (c == LAT + 2) begin
        tests++;
        if (q_count !== 3'd3 || imem_req !== 1'b0) begin
          fails++; $display("FAIL stall_limit: got cnt=%0d req=%b expected 3/0", q_count, imem_req);
        end
      end
      if (c >= LAT + 3 && c < LAT + 6) begin
        tests++;
        if (q_count !== 3'd4 || imem_req !== 1'b0) begin
          fails++; $display("FAIL stall_full c%0d: got cnt=%0d req=%b expected 4/0", c, q_count, imem_req);
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 1; c <= LAT + 4; c++) begin
      cyc(); @(negedge clk);
    end
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    load_stream(32'h0000_0040, 64);
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL redir_noreq: got %b expected 0", imem_req);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 1) redirect = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        tests++;
        if (q_count !== 3'd0 || imem_addr !== 10'h010 || imem_req !== 1'b1) begin
          fails++; $display("FAIL redir_r1: got cnt=%0d addr=%h req=%b expected 0/010/1", q_count, imem_addr, imem_req);
        end
      end
      if (k < LAT + 1) begin
        tests++;
        if (if_valid !== 1'b0) begin
          fails++; $display("FAIL redir_bubble r+%0d: got %b expected 0", k, if_valid);
        end
      end
      if (k == LAT + 1) begin
        tests++;
        if (if_valid !== 1'b1 || if_instr !== 32'h1000_0010 || if_pcplus4 !== 32'h44) begin
          fails++; $display("FAIL redir_target: got %b %h %h expected 1 10000010 00000044", if_valid, if_instr, if_pcplus4);
        end
      end
    end
  endtask

  task automatic test_redirect_stall_full();
    int n;
    do_reset();
    for (int c = 1; c <= LAT + 4; c++) begin
      cyc();
      if (c == LAT) stall = 1'b1;
      @(negedge clk);
      if (c == LAT + 3) begin
        tests++;
        if (q_count !== 3'd4) begin
          fails++; $display("FAIL rsf_full: got %0d expected 4", q_count);
        end
      end
    end
    cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    load_stream(32'h0000_0080, 64);
    @(negedge clk);
    cyc();
    redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    tests++;
    if (q_count !== 3'd0) begin
      fails++; $display("FAIL rsf_flush: got %0d expected 0", q_count);
    end
    n = 0;
    while (!if_valid && n < 10) begin
      cyc(); @(negedge clk); n++;
    end
    tests++;
    if (!if_valid) begin
      fails++; $display("FAIL rsf_timeout: got no valid head expected target within 10 cycles");
    end else if (if_instr !== 32'h1000_0020 || if_pcplus4 !== 32'h84) begin
      fails++; $display("FAIL rsf_target: got %h %h expected 10000020 00000084", if_instr, if_pcplus4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 1; c <= LAT + 2; c++) begin
      cyc();
      if (c == LAT) stall = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (q_count !== 3'd3) begin
      fails++; $display("FAIL rmid_pre: got %0d expected 3", q_count);
    end
    cyc();
    rst = 1'b1; stall = 1'b0;
    load_stream(32'h0, 64);
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL rmid_req: got %b expected 0", imem_req);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pcplus4 !== 32'h0 || q_count !== 3'd0 || imem_addr !== 10'h0) begin
      fails++;
      $display("FAIL rmid_out: got %b %h %h %0d %h expected 0 0 0 0 000", if_valid, if_instr, if_pcplus4, q_count, imem_addr);
    end
    for (int k = 1; k <= LAT; k++) begin
      cyc(); @(negedge clk);
    end
    tests++;
    if (if_valid !== 1'b1 || if_instr !== 32'h1000_0000 || if_pcplus4 !== 32'h4) begin
      fails++; $display("FAIL rmid_restart: got %b %h %h expected 1 10000000 00000004", if_valid, if_instr, if_pcplus4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    load_stream(32'hFFFF_FFF8, 64);
    @(negedge clk);
    for (int k = 1; k <= LAT + 3; k++) begin
      cyc();
      if (k == 1) redirect = 1'b0;
      @(negedge clk);
      if (k == 3) begin
        tests++;
        if (imem_addr !== 10'h000) begin
          fails++; $display("FAIL wrap_addr: got %h expected 000", imem_addr);
        end
      end
      if (k == LAT + 2) begin
        tests++;
        if (if_valid !== 1'b1 || if_instr !== 32'h1000_03FF || if_pcplus4 !== 32'h0) begin
          fails++; $display("FAIL wrap_pc4: got %b %h %h expected 1 100003ff 00000000", if_valid, if_instr, if_pcplus4);
        end
      end
      if (k == LAT + 3) begin
        tests++;
        if (if_instr !== 32'h1000_0000 || if_pcplus4 !== 32'h4) begin
          fails++; $display("FAIL wrap_next: got %h %h expected 10000000 00000004", if_instr, if_pcplus4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall_full();
    test_reset_mid();
    test_wrap();
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
